// File: rtl/async_fifo_wr_ptr_pkg.sv
// Shared pointer helpers for the async FIFO: pointer width, binary-to-Gray
// encoding and the Gray-domain full comparison.
package fifo_pkg;

    localparam int MAX_PTR_W = 32;
    typedef logic [MAX_PTR_W-1:0] ptr_word_t;

    function automatic int ptr_width(input int addr_width);
        return addr_width + 1;
    endfunction

    function automatic ptr_word_t bin2gray(input ptr_word_t b);
        return b ^ (b >> 1);
    endfunction

    // Full when the write Gray pointer equals the read Gray pointer with its
    // top two bits inverted: same address, opposite lap.
    function automatic ptr_word_t full_cmp(input ptr_word_t g, input int width);
        return g ^ (ptr_word_t'(2'b11) << (width - 2));
    endfunction

endpackage

// File: rtl/async_fifo_wr_ptr_if.sv
// Write-side handshake and pointer bundle between the producer, the
// write-pointer stage and the read-domain synchroniser.
interface async_fifo_wr_ptr_if #(
    parameter int ADDR_WIDTH = 4
);
    import fifo_pkg::*;

    localparam int PW = ptr_width(ADDR_WIDTH);

    logic                  wr_en;
    logic [PW-1:0]         rptr_gray;
    logic                  wr_accept;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [PW-1:0]         wptr_gray;
    logic                  wfull;
    logic                  walmost_full;
    logic [PW-1:0]         wlevel;
    logic                  wr_overflow;

    modport master (
        output wr_en, rptr_gray,
        input  wr_accept, waddr, wptr_gray, wfull, walmost_full, wlevel, wr_overflow
    );

    modport slave (
        input  wr_en, rptr_gray,
        output wr_accept, waddr, wptr_gray, wfull, walmost_full, wlevel, wr_overflow
    );

endinterface

// File: rtl/async_fifo_wr_ptr_gray2bin.sv
// Gray-to-binary decoder: each binary bit is the XOR of all Gray bits at and
// above its position.
module my_gray2bin #(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    always_comb begin
        // NOTE: default first so no path through this block can infer a latch.
        bin = '0;
        for (int i = 0; i < WIDTH; i++) begin
            bin[i] = ^(gray >> i);
        end
    end

endmodule

// File: rtl/async_fifo_wr_ptr.sv
// Write-domain pointer/flag stage of the async FIFO: binary and Gray write
// pointers, read-pointer synchroniser, and full/almost-full/level/overflow flags.
module async_fifo_wr_ptr
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH   = 4,
    parameter int SYNC_STAGES  = 2,
    parameter int AFULL_THRESH = 12
) (
    input logic                clk,
    input logic                rst_n,
    async_fifo_wr_ptr_if.slave bus
);

    localparam int            PW        = ptr_width(ADDR_WIDTH);
    localparam logic [PW-1:0] AFULL_LVL = PW'(AFULL_THRESH);

    logic [PW-1:0] rq_s;
    logic [PW-1:0] rbin_s;
    logic [PW-1:0] wbin;
    logic [PW-1:0] wbin_next;
    logic [PW-1:0] wgray_next;
    logic [PW-1:0] full_gray;
    logic [PW-1:0] level_next;
    logic [PW-1:0] wptr_gray_q;
    logic [PW-1:0] wlevel_q;
    logic          wr_accept;
    logic          wfull_q;
    logic          afull_q;
    logic          overflow_q;

    // Read-pointer synchroniser: plain flop chain, nothing ahead of stage 0.
    for (genvar k = 0; k < SYNC_STAGES; k++) begin : g_sync
        logic [PW-1:0] q;
        if (k == 0) begin : g_first
            // NOTE: every synchroniser flop is reset so the synchronised read
            // pointer restarts at zero together with the read side.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) q <= '0;
                else        q <= bus.rptr_gray;
            end
        end else begin : g_rest
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) q <= '0;
                else        q <= g_sync[k-1].q;
            end
        end
    end

    assign rq_s = g_sync[SYNC_STAGES-1].q;

    my_gray2bin #(.WIDTH(PW)) u_gray2bin (
        .gray (rq_s),
        .bin  (rbin_s)
    );

    assign wr_accept  = bus.wr_en & ~wfull_q;
    assign wbin_next  = wbin + PW'(wr_accept);
    assign wgray_next = PW'(bin2gray(ptr_word_t'(wbin_next)));
    assign full_gray  = PW'(full_cmp(ptr_word_t'(rq_s), PW));
    // Modular subtract keeps the level right across pointer wrap.
    assign level_next = wbin_next - rbin_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wbin        <= '0;
            wptr_gray_q <= '0;
            wfull_q     <= 1'b0;
            afull_q     <= 1'b0;
            wlevel_q    <= '0;
            overflow_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flag sees the same
            // pre-edge pointer values, independent of statement order.
            wbin        <= wbin_next;
            wptr_gray_q <= wgray_next;
            wfull_q     <= (wgray_next == full_gray);
            afull_q     <= (level_next >= AFULL_LVL);
            wlevel_q    <= level_next;
            overflow_q  <= bus.wr_en & wfull_q;
        end
    end

    assign bus.wr_accept    = wr_accept;
    assign bus.waddr        = wbin[ADDR_WIDTH-1:0];
    assign bus.wptr_gray    = wptr_gray_q;
    assign bus.wfull        = wfull_q;
    assign bus.walmost_full = afull_q;
    assign bus.wlevel       = wlevel_q;
    assign bus.wr_overflow  = overflow_q;

endmodule

// File: tb/tb_async_fifo_wr_ptr.sv
// Scoreboard bench for async_fifo_wr_ptr (ADDR_WIDTH=4, SYNC_STAGES=2,
// AFULL_THRESH=12): the driver queues the expected state, a monitor compares.
module tb_async_fifo_wr_ptr;

    localparam int AW    = 4;
    localparam int PW    = AW + 1;
    localparam int DEPTH = 1 << AW;

    typedef struct {
        string         name;
        logic [PW-1:0] wbin;
        logic [PW-1:0] lvl;
        logic          full;
        logic          afull;
        logic          ovf;
        logic          acc;
        bit            chk_acc;
    } exp_t;

    logic clk;
    logic rst_n;

    async_fifo_wr_ptr_if #(.ADDR_WIDTH(AW)) bus ();

    async_fifo_wr_ptr #(
        .ADDR_WIDTH   (AW),
        .SYNC_STAGES  (2),
        .AFULL_THRESH (12)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference state: write pointer, current full flag, and the read
    // pointers driven one and two clocks ago (two-flop synchroniser delay).
    logic [PW-1:0] m_wbin;
    logic [PW-1:0] m_rb1;
    logic [PW-1:0] m_rb2;
    logic          m_full;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [PW-1:0] to_gray(input logic [PW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_wbin = '0;
        m_rb1  = '0;
        m_rb2  = '0;
        m_full = 1'b0;
    endtask

    // One write-clock cycle: drive inputs, predict the registered outputs
    // seen after the next rising edge and queue them.
    task automatic step(input logic we, input logic [PW-1:0] rb, input string nm);
        exp_t          e;
        logic          acc;
        logic          ovf;
        logic [PW-1:0] lvl;
        @(negedge clk);
        bus.wr_en     = we;
        bus.rptr_gray = to_gray(rb);
        acc    = we & ~m_full;
        ovf    = we & m_full;
        m_wbin = m_wbin + PW'(acc);
        lvl    = m_wbin - m_rb2;
        m_full = (lvl == PW'(DEPTH));
        m_rb2  = m_rb1;
        m_rb1  = rb;
        e.name    = nm;
        e.wbin    = m_wbin;
        e.lvl     = lvl;
        e.full    = m_full;
        e.afull   = (lvl >= PW'(12));
        e.ovf     = ovf;
        e.acc     = we & ~m_full;
        e.chk_acc = 1'b1;
        sb.push_back(e);
    endtask

    // Monitor: registered outputs settle just after a rising edge; reset
    // clears them as soon as rst_n falls.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk or negedge rst_n);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n_vec++;
                check({e.name, ".waddr"},        32'(bus.waddr),        32'(e.wbin[AW-1:0]));
                check({e.name, ".wptr_gray"},    32'(bus.wptr_gray),    32'(to_gray(e.wbin)));
                check({e.name, ".wlevel"},       32'(bus.wlevel),       32'(e.lvl));
                check({e.name, ".wfull"},        32'(bus.wfull),        32'(e.full));
                check({e.name, ".walmost_full"}, 32'(bus.walmost_full), 32'(e.afull));
                check({e.name, ".wr_overflow"},  32'(bus.wr_overflow),  32'(e.ovf));
                if (e.chk_acc)
                    check({e.name, ".wr_accept"}, 32'(bus.wr_accept),   32'(e.acc));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, %0d vectors, %0d miscompares", n_vec, n_err);
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t          r;
        logic [PW-1:0] rp;

        rst_n         = 1'b0;
        bus.wr_en     = 1'b0;
        bus.rptr_gray = '0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Burst, then asynchronous reset in the middle of it with wr_en high.
        for (int i = 0; i < 6; i++) step(1'b1, '0, "burst");
        @(posedge clk);
        #3;
        r.name    = "reset";
        r.wbin    = '0;
        r.lvl     = '0;
        r.full    = 1'b0;
        r.afull   = 1'b0;
        r.ovf     = 1'b0;
        r.acc     = 1'b0;
        r.chk_acc = 1'b0;
        sb.push_back(r);
        model_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        bus.wr_en = 1'b0;
        rst_n     = 1'b1;

        // Fill 16 entries with the read pointer parked at zero.
        for (int i = 0; i < DEPTH; i++) step(1'b1, '0, "fill");

        // Writes while full are dropped and flagged each cycle.
        for (int i = 0; i < 3; i++) step(1'b1, '0, "overflow");
        step(1'b0, '0, "overflow_end");

        // One read: full releases on the third edge after the pointer moves.
        for (int i = 0; i < 3; i++) step(1'b0, PW'(1), "release");

        // Drain with the read pointer advancing one Gray step per clock.
        for (int i = 2; i < DEPTH; i++) step(1'b0, PW'(i), "ramp");
        step(1'b0, PW'(15), "ramp");
        step(1'b0, PW'(15), "ramp");

        // Streaming across the pointer wrap with the reader one entry behind.
        for (int i = 0; i < 40; i++) step(1'b1, m_wbin - PW'(1), "wrap");

        // Build level 8, then write every clock while the reader keeps pace.
        for (int i = 0; i < 7; i++) step(1'b1, PW'(23), "sim_fill");
        rp = PW'(24);
        for (int i = 0; i < 2; i++) begin
            step(1'b0, rp, "sim_lead");
            rp = rp + PW'(1);
        end
        for (int i = 0; i < 10; i++) begin
            step(1'b1, rp, "simultaneous");
            rp = rp + PW'(1);
        end
        for (int i = 0; i < 3; i++) step(1'b0, rp - PW'(1), "tail");

        @(posedge clk);
        #2;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL sb_drain: got %0d pending entries, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
